// File: rtl/axonerve_kvs_rtl_rd_sched.sv
// AXI4 read-burst scheduler: splits a byte-sized request into AR bursts, caps in-flight
// bursts with an up/down counter and pulses ctrl_done once every burst's last beat is back.
module axonerve_kvs_rtl_rd_sched #(
    parameter int unsigned C_ADDR_WIDTH      = 64,
    parameter int unsigned C_DATA_WIDTH      = 512,
    parameter int unsigned C_XFER_SIZE_WIDTH = 32,
    parameter int unsigned C_BURST_LEN       = 64,
    parameter int unsigned C_MAX_OUTSTANDING = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         ctrl_start,
    input  logic [C_ADDR_WIDTH-1:0]      ctrl_addr_offset,
    input  logic [C_XFER_SIZE_WIDTH-1:0] ctrl_xfer_size_in_bytes,
    output logic                         ctrl_busy,
    output logic                         ctrl_done,
    output logic                         m_axi_arvalid,
    input  logic                         m_axi_arready,
    output logic [C_ADDR_WIDTH-1:0]      m_axi_araddr,
    output logic [7:0]                   m_axi_arlen,
    input  logic                         m_axi_rvalid,
    input  logic                         m_axi_rready,
    input  logic                         m_axi_rlast
);

    localparam int unsigned Bpb    = C_DATA_WIDTH / 8;
    localparam int unsigned LogBpb = $clog2(Bpb);
    localparam int unsigned LogBl  = $clog2(C_BURST_LEN);
    localparam int unsigned OutW   = $clog2(C_MAX_OUTSTANDING) + 1;
    localparam int unsigned CntW   = C_XFER_SIZE_WIDTH + 1;

    localparam logic [C_ADDR_WIDTH-1:0] AddrMask = ~(C_ADDR_WIDTH'(Bpb - 1));
    localparam logic [C_ADDR_WIDTH-1:0] AddrStep = C_ADDR_WIDTH'(C_BURST_LEN * Bpb);
    localparam logic [OutW-1:0]         MaxOut   = OutW'(C_MAX_OUTSTANDING);
    localparam logic [7:0]              FullLen  = 8'(C_BURST_LEN - 1);

    typedef enum logic [2:0] {StIdle, StCalc, StIssue, StDrain, StDone} state_e;

    state_e                  state_q, state_d;
    logic [C_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                    arvalid_q, arvalid_d;
    logic [7:0]              arlen_q, arlen_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic [CntW-1:0]         beats_q, beats_d;
    logic [CntW-1:0]         total_q, total_d;
    logic [8:0]              last_len_q, last_len_d;
    logic [CntW-1:0]         issued_q, issued_d;
    logic [CntW-1:0]         rlast_cnt_q, rlast_cnt_d;
    logic [OutW-1:0]         outst_q, outst_d;

    logic            ar_hs, r_hs, below_max;
    logic [CntW-1:0] beats_calc, calc_total;

    assign ar_hs      = arvalid_q & m_axi_arready;
    assign r_hs       = m_axi_rvalid & m_axi_rready & m_axi_rlast;
    assign beats_calc = ({1'b0, ctrl_xfer_size_in_bytes} + CntW'(Bpb - 1)) >> LogBpb;
    assign calc_total = (beats_q + CntW'(C_BURST_LEN - 1)) >> LogBl;
    assign below_max  = outst_d < MaxOut;

    // Simultaneous AR and R-last handshakes cancel; a decrement at zero saturates.
    always_comb begin
        outst_d = outst_q;
        if (ar_hs && !r_hs) begin
            outst_d = outst_q + OutW'(1);
        end else if (!ar_hs && r_hs && outst_q != '0) begin
            outst_d = outst_q - OutW'(1);
        end
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        arvalid_d   = arvalid_q;
        arlen_d     = arlen_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        beats_d     = beats_q;
        total_d     = total_q;
        last_len_d  = last_len_q;
        issued_d    = issued_q;
        rlast_cnt_d = rlast_cnt_q;
        if (r_hs && (state_q == StIssue || state_q == StDrain)) begin
            rlast_cnt_d = rlast_cnt_q + CntW'(1);
        end
        case (state_q)
            StIdle: begin
                if (ctrl_start) begin
                    addr_d      = ctrl_addr_offset & AddrMask;
                    beats_d     = beats_calc;
                    issued_d    = '0;
                    rlast_cnt_d = '0;
                    busy_d      = 1'b1;
                    state_d     = StCalc;
                end
            end
            StCalc: begin
                total_d    = calc_total;
                last_len_d = 9'(beats_q - ((calc_total - CntW'(1)) << LogBl));
                if (beats_q == '0) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = StDone;
                end else begin
                    arvalid_d = below_max;
                    arlen_d   = (calc_total == CntW'(1)) ? 8'(last_len_d - 9'd1) : FullLen;
                    state_d   = StIssue;
                end
            end
            StIssue: begin
                if (ar_hs) begin
                    addr_d   = addr_q + AddrStep;
                    issued_d = issued_q + CntW'(1);
                    if (issued_d == total_q) begin
                        arvalid_d = 1'b0;
                        state_d   = StDrain;
                    end else begin
                        arvalid_d = below_max;
                        // The burst about to be presented is the final one.
                        arlen_d   = (issued_d == total_q - CntW'(1)) ?
                                    8'(last_len_q - 9'd1) : FullLen;
                    end
                end else if (!arvalid_q) begin
                    arvalid_d = below_max;
                end
            end
            StDrain: begin
                if (rlast_cnt_d == total_q && outst_d == '0) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            arvalid_q   <= 1'b0;
            arlen_q     <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            beats_q     <= '0;
            total_q     <= '0;
            last_len_q  <= '0;
            issued_q    <= '0;
            rlast_cnt_q <= '0;
            outst_q     <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            arvalid_q   <= arvalid_d;
            arlen_q     <= arlen_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            beats_q     <= beats_d;
            total_q     <= total_d;
            last_len_q  <= last_len_d;
            issued_q    <= issued_d;
            rlast_cnt_q <= rlast_cnt_d;
            outst_q     <= outst_d;
        end
    end

    assign ctrl_busy     = busy_q;
    assign ctrl_done     = done_q;
    assign m_axi_arvalid = arvalid_q;
    assign m_axi_araddr  = addr_q;
    assign m_axi_arlen   = arlen_q;

endmodule

// File: doc/axonerve_kvs_rtl_rd_sched.md
# axonerve_kvs_rtl_rd_sched

Read-burst scheduler for the KVS kernel's AXI4 memory master. From one start pulse it turns a byte-sized transfer request into a sequence of AR bursts and caps the number of in-flight bursts with an up/down outstanding counter. It watches R-channel last-beat handshakes to detect completion, then signals done. It sits between the kernel control FSM and the AXI read master's data path. It drives only the AR channel.

## Interface
Parameters:
- C_ADDR_WIDTH, 64, AXI address width.
- C_DATA_WIDTH, 512, AXI data width in bits; BPB = C_DATA_WIDTH/8 bytes per beat.
- C_XFER_SIZE_WIDTH, 32, width of the byte-count input.
- C_BURST_LEN, 64, maximum beats per burst; power of 2, 2..256.
- C_MAX_OUTSTANDING, 16, maximum AR bursts issued without a matching R last; power of 2, ≥2.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- ctrl_start  in  1  single-cycle start request.
- ctrl_addr_offset  in  C_ADDR_WIDTH  byte start address; sampled with ctrl_start.
- ctrl_xfer_size_in_bytes  in  C_XFER_SIZE_WIDTH  byte count; sampled with ctrl_start.
- ctrl_busy  out  1  high from the accepted start until done.
- ctrl_done  out  1  single-cycle completion pulse.
- m_axi_arvalid  out  1  AR valid.
- m_axi_arready  in  1  AR ready.
- m_axi_araddr  out  C_ADDR_WIDTH  burst address.
- m_axi_arlen  out  8  beats minus 1.
- m_axi_rvalid, m_axi_rready, m_axi_rlast  in  1 each  R-channel handshake monitor (the block does not drive rready).

## Operation
- States: IDLE, CALC, ISSUE, DRAIN, DONE.
- IDLE:
  - ctrl_start registers the address with its low log2(BPB) bits forced to 0.
  - It computes beats = ceil(size/BPB), in C_XFER_SIZE_WIDTH+1 bits, no overflow.
  - ctrl_busy←1, then go to CALC.
- ctrl_start outside IDLE is ignored. It has no effect on any state or count.
- CALC (1 cycle):
  - bursts_total = ceil(beats/C_BURST_LEN).
  - last_len = beats − (bursts_total−1)·C_BURST_LEN.
  - If beats==0, go to DONE; otherwise go to ISSUE.
- ISSUE:
  - Present the burst with arlen = C_BURST_LEN−1, except the final burst, which uses last_len−1.
  - arvalid is asserted only while outstanding < C_MAX_OUTSTANDING.
  - On an AR handshake: araddr += C_BURST_LEN·BPB, bursts_issued++, outstanding++.
  - After the final AR handshake, go to DRAIN.
- Outstanding counter, width log2(C_MAX_OUTSTANDING)+1:
  - It counts up on an AR handshake and down on an R handshake with rlast.
  - If both happen in the same cycle, it holds its value.
  - It never wraps. A decrement at 0 is a protocol error and the counter saturates at 0.
- DRAIN: once bursts_total rlast handshakes have been counted in total and outstanding==0, go to DONE.
- DONE (1 cycle): ctrl_done=1, ctrl_busy←0, then go to IDLE.
- No 4 KiB splitting. The caller aligns ctrl_addr_offset to C_BURST_LEN·BPB.
- rst in any state: state←IDLE, all counters cleared, in-flight bursts forgotten.

## Timing
- Reset values:
  - ctrl_busy=0, ctrl_done=0, m_axi_arvalid=0, m_axi_araddr=0, m_axi_arlen=0.
  - Outstanding count = 0.
- All outputs are registered.
- Start latency: with ctrl_start at cycle T, ctrl_busy=1 at T+1 and the earliest arvalid is at T+2.
- Zero-size request: ctrl_done at T+2, no AR issued.
- AXI rule: once arvalid is asserted, araddr and arlen hold and arvalid stays high until arready.
- Throughput: with arready held at 1, back-to-back AR handshakes occur at one per cycle while under the limit.
- Limit release:
  - When outstanding==C_MAX_OUTSTANDING and an rlast handshake occurs at cycle N, arvalid may reassert at N+1.
  - An AR handshake in the cycle that reaches the limit drops arvalid the next cycle.
- Completion: ctrl_done pulses the cycle after the final rlast handshake (DRAIN→DONE registered). ctrl_busy falls in the same cycle that ctrl_done is high.
- A new ctrl_start is accepted the cycle after ctrl_done.

## Test plan
- Single beat: addr 0x1000, size 64, C_DATA_WIDTH=512. Expect one AR with araddr 0x1000, arlen 0. Return one beat with rlast; ctrl_done follows 1 cycle later.
- Multi-burst: addr 0x0, size 3·4096+64, arready=1. Expect 4 ARs: araddr 0x0, 0x1000, 0x2000, 0x3000 and arlen 63, 63, 63, 0. ctrl_done only after the 4th rlast.
- Outstanding cap: size 32·4096, arready=1, no R beats. Expect exactly 16 AR handshakes, then arvalid low. After one rlast, exactly one more AR. Also apply a simultaneous AR handshake and rlast and check the count holds.
- Zero size and ignored start:
  - size 0 gives ctrl_done at T+2 with no arvalid.
  - A second ctrl_start with different address and size while ctrl_busy=1 changes nothing.
- AR backpressure: hold arready=0 for 5 cycles during ISSUE. araddr and arlen must stay stable and arvalid must stay high.
- Reset mid-transfer: assert rst after 3 ARs are issued. The next cycle all outputs are 0 and state is IDLE. A fresh start of size 64 then completes normally.
